sram_a_column_reader: RTL and testbench

// - Read-side initiator for the single-port matrix SRAM (en, active-low wen, 1-cycle registered read).
// - On start, streams an N x N row-major matrix out of the SRAM one column at a time.
// - Each column is presented as one N-element vector on a valid/ready port.
// - Sits between the matrix SRAM and the systolic-array input skew stage. Never writes to the SRAM.

---
 rtl/sram_a_column_reader_pkg.sv | 16 +
 rtl/sram_a_column_reader.sv | 130 +++++++++++++
 tb/tb_sram_a_column_reader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_a_column_reader_pkg.sv
// Shared definitions for the matrix SRAM readers/writers: FSM state encoding
// and SRAM write-enable levels (wen is active-low).
package sram_a_column_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam logic WEN_READ  = 1'b1;
    localparam logic WEN_WRITE = 1'b0;

endpackage

// File: rtl/sram_a_column_reader.sv
// Streams an N x N row-major matrix out of a single-port SRAM one column at a
// time, presenting each column as an N-element vector on a valid/ready port.
module sram_a_column_reader
    import sram_a_column_reader_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11,
    parameter int N      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_en,
    output logic                  sram_wen,
    output logic [ADDR_W-1:0]     sram_addr,
    input  logic [DATA_W-1:0]     sram_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*DATA_W-1:0]   out_data
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [CW-1:0]     col;
    logic [CW-1:0]     fetch_row;
    logic [CW-1:0]     cap_row;
    logic              rd_pend;
    logic              last_cap;

    // Element address of A[row][col]; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] elem_addr(
        input logic [ADDR_W-1:0] base,
        input logic [CW-1:0]     row,
        input logic [CW-1:0]     c
    );
        return base + (ADDR_W'(row) * ADDR_W'(N)) + ADDR_W'(c);
    endfunction

    assign sram_wen = WEN_READ;
    assign last_cap = rd_pend && (cap_row == CW'(N-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sram_en   <= 1'b0;
            sram_addr <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            base_q    <= '0;
            col       <= '0;
            fetch_row <= '0;
            cap_row   <= '0;
            rd_pend   <= 1'b0;
        end else begin
            // Read data returns one edge after the SRAM samples the address.
            rd_pend <= sram_en;

            case (state)
                ST_IDLE: begin
                    done    <= 1'b0;
                    sram_en <= 1'b0;
                    if (start) begin
                        base_q    <= base_addr;
                        col       <= '0;
                        busy      <= 1'b1;
                        sram_en   <= 1'b1;
                        sram_addr <= elem_addr(base_addr, '0, '0);
                        fetch_row <= CW'(1);
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    sram_en   <= 1'b1;
                    sram_addr <= elem_addr(base_q, fetch_row, col);
                    if (fetch_row == CW'(N-1)) begin
                        state <= ST_DRAIN;
                    end else begin
                        fetch_row <= fetch_row + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    sram_en <= 1'b0;
                    if (last_cap) begin
                        out_valid <= 1'b1;
                        state     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    sram_en <= 1'b0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (col == CW'(N-1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_DONE;
                        end else begin
                            // Next column starts fetching on the handshake edge.
                            col       <= col + 1'b1;
                            sram_en   <= 1'b1;
                            sram_addr <= elem_addr(base_q, '0, col + 1'b1);
                            fetch_row <= CW'(1);
                            state     <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    sram_en <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (rd_pend) begin
                out_data[DATA_W*cap_row +: DATA_W] <= sram_q;
                cap_row <= (cap_row == CW'(N-1)) ? '0 : cap_row + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_a_column_reader.sv
// Directed bench for sram_a_column_reader with a behavioural 1-cycle SRAM.
module tb_sram_a_column_reader;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 11;
    localparam int N      = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic                busy;
    logic                done;
    logic                sram_en;
    logic                sram_wen;
    logic [ADDR_W-1:0]   sram_addr;
    logic [DATA_W-1:0]   sram_q;
    logic                out_valid;
    logic                out_ready;
    logic [N*DATA_W-1:0] out_data;

    logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    bit wen_bad     = 1'b0;

    logic [31:0] exp_a [4] = '{32'h0C080400, 32'h0D090501, 32'h0E0A0602, 32'h0F0B0703};
    logic [31:0] exp_w [4] = '{32'h8C888480, 32'h8D898581, 32'h8E8A8682, 32'h8F8B8783};

    sram_a_column_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .sram_en   (sram_en),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_q    (sram_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_en && sram_wen) sram_q <= mem[sram_addr];
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (sram_wen !== 1'b1) wen_bad <= 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, " valid"}, 64'(out_valid), 64'd1);
    endtask

    // Waits for a column, checks it, and completes the handshake (out_ready=1).
    task automatic take_col(input string tag, input logic [31:0] exp);
        wait_valid(tag);
        check({tag, " data"}, 64'(out_data), 64'(exp));
        step();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " busy@done"}, 64'(busy), 64'd0);
        step();
        check({tag, " done pulse end"}, 64'(done), 64'd0);
        check({tag, " busy idle"}, 64'(busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " sram_en"}, 64'(sram_en), 64'd0);
        check({tag, " out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " sram_addr"}, 64'(sram_addr), 64'd0);
        check({tag, " out_data"}, 64'(out_data), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        out_ready = 1'b1;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) mem[i] = DATA_W'(i);

        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Timing and contents of a plain matrix read
        start = 1'b1;
        step();
        start = 1'b0;
        check("t0 sram_en", 64'(sram_en), 64'd1);
        check("t0 addr", 64'(sram_addr), 64'd0);
        check("t0 busy", 64'(busy), 64'd1);
        for (int r = 1; r < 4; r++) begin
            step();
            check("tr sram_en", 64'(sram_en), 64'd1);
            check("tr addr", 64'(sram_addr), 64'(4 * r));
        end
        step();
        check("t4 sram_en", 64'(sram_en), 64'd0);
        check("t4 out_valid", 64'(out_valid), 64'd0);
        step();
        check("t5 out_valid", 64'(out_valid), 64'd1);
        check("t5 col0", 64'(out_data), 64'(exp_a[0]));
        step();
        for (int c = 1; c < 4; c++) take_col("plain col", exp_a[c]);
        wait_done("plain");
        check("plain done count", 64'(done_cnt), 64'd1);

        // Backpressure in column 1
        start = 1'b1;
        step();
        start = 1'b0;
        take_col("bp col0", exp_a[0]);
        out_ready = 1'b0;
        wait_valid("bp col1");
        for (int k = 0; k < 7; k++) begin
            check("bp hold data", 64'(out_data), 64'(exp_a[1]));
            check("bp hold valid", 64'(out_valid), 64'd1);
            check("bp sram_en", 64'(sram_en), 64'd0);
            step();
        end
        check("bp col1 data", 64'(out_data), 64'(exp_a[1]));
        out_ready = 1'b1;
        step();
        take_col("bp col2", exp_a[2]);
        take_col("bp col3", exp_a[3]);
        wait_done("bp");
        check("bp done count", 64'(done_cnt), 64'd2);

        // Address wrap from 0x7FE
        for (int k = 0; k < 16; k++) begin
            logic [ADDR_W-1:0] a;
            a = 11'h7FE + ADDR_W'(k);
            mem[a] = 8'h80 + DATA_W'(k);
        end
        base_addr = 11'h7FE;
        start = 1'b1;
        step();
        start = 1'b0;
        check("wrap addr0", 64'(sram_addr), 64'h7FE);
        step();
        check("wrap addr1", 64'(sram_addr), 64'h002);
        for (int c = 0; c < 4; c++) take_col("wrap col", exp_w[c]);
        wait_done("wrap");
        check("wrap done count", 64'(done_cnt), 64'd3);

        // Reset during FETCH of column 2
        for (int i = 0; i < 16; i++) mem[i] = DATA_W'(i);
        base_addr = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        take_col("rst col0", exp_a[0]);
        take_col("rst col1", exp_a[1]);
        check("rst fetch en", 64'(sram_en), 64'd1);
        step();
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (3) step();
        check("midreset no done", 64'(done_cnt), 64'd3);
        rst_n = 1'b1;
        step();
        check("post reset idle", 64'(busy), 64'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 4; c++) take_col("rerun col", exp_a[c]);
        wait_done("rerun");
        check("rerun done count", 64'(done_cnt), 64'd4);

        // start held high through the whole matrix and the DONE cycle
        start = 1'b1;
        step();
        for (int c = 0; c < 4; c++) take_col("hold col", exp_a[c]);
        wait_done("hold");
        start = 1'b0;
        step();
        check("hold no restart", 64'(busy), 64'd0);
        check("hold done count", 64'(done_cnt), 64'd5);
        check("sram_wen always 1", 64'(wen_bad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
